// File: rtl/dfe_decim_pkg.sv
// Shared types and helpers for the DFE decimator: sample type, saturation and phase clamping.
package dfe_decim_pkg;

   localparam int unsigned SAMPLE_WIDTH = 16;
   localparam int unsigned WIDE_WIDTH   = 64;

   typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
   typedef logic signed [WIDE_WIDTH-1:0]   wide_t;

   // Clamp a wide signed value into the range of a width-bit signed number.
   function automatic wide_t sat_wide(input wide_t value, input int unsigned width);
      wide_t max_v;
      wide_t min_v;
      max_v = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
      min_v = -(wide_t'(1) <<< (width - 1));
      if (value > max_v) begin
         sat_wide = max_v;
      end else if (value < min_v) begin
         sat_wide = min_v;
      end else begin
         sat_wide = value;
      end
   endfunction

   function automatic sample_t sat_to_sample(input wide_t value);
      sat_to_sample = sample_t'(sat_wide(value, SAMPLE_WIDTH));
   endfunction

   function automatic int unsigned clamp_phase(input int unsigned sel, input int unsigned m);
      clamp_phase = (sel > m - 1) ? (m - 1) : sel;
   endfunction

endpackage

// File: rtl/decim_out_fifo.sv
// Single-clock show-ahead FIFO; head reads as zero while empty, all state gated by clk_enable.
module decim_out_fifo #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clk_enable,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
   localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr_q;
   logic [PTR_WIDTH-1:0]  rd_ptr_q;
   logic [CNT_WIDTH-1:0]  count_q;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count_q == CNT_WIDTH'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = clk_enable & pop & ~empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = clk_enable & push & (~full | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (!do_push && do_pop) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/decimator.sv
// Keep-one-in-M down-sampler with output FIFO; DECIMATOR_AVG_EN selects integrate-and-dump
// averaging of each frame instead of a plain pick.
module decimator
   import dfe_decim_pkg::*;
#(
   parameter int unsigned DATA_WIDTH        = 16,
   parameter int unsigned DECIMATION_FACTOR = 3,
   parameter int unsigned OUT_FIFO_DEPTH    = 4,
   parameter int unsigned AVG_SHIFT         = $clog2(DECIMATION_FACTOR),
   localparam int unsigned COUNTER_WIDTH    = $clog2(DECIMATION_FACTOR)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clk_enable,
   input  logic signed [DATA_WIDTH-1:0] dec_in,
   input  logic                         dec_in_valid,
   input  logic                         sync,
   input  logic [COUNTER_WIDTH-1:0]     phase_sel,
   output logic signed [DATA_WIDTH-1:0] dec_out,
   output logic                         dec_out_valid,
   input  logic                         dec_out_ready,
   output logic                         overflow
);

   localparam logic [COUNTER_WIDTH-1:0] LAST_POS = COUNTER_WIDTH'(DECIMATION_FACTOR - 1);

   if (DECIMATION_FACTOR < 2) begin : g_bad_factor
      $error("DECIMATION_FACTOR must be at least 2");
   end
   if ((OUT_FIFO_DEPTH < 2) || ((OUT_FIFO_DEPTH & (OUT_FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("OUT_FIFO_DEPTH must be a power of two and at least 2");
   end
   if (AVG_SHIFT >= WIDE_WIDTH) begin : g_bad_shift
      $error("AVG_SHIFT is out of range");
   end

   logic [COUNTER_WIDTH-1:0] counter_q;
   logic [COUNTER_WIDTH-1:0] counter_d;
   logic [COUNTER_WIDTH-1:0] phase_q;
   logic [COUNTER_WIDTH-1:0] eff_cnt;
   logic [COUNTER_WIDTH-1:0] eff_phase;
   logic                     accept;
   logic                     keep;
   logic                     pop;
   logic                     drop;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     overflow_q;
   logic                     overflow_d;
   logic [DATA_WIDTH-1:0]    push_data;
   logic [DATA_WIDTH-1:0]    fifo_head;

   // sync takes effect in its own cycle: a coincident sample sits at position 0.
   always_comb begin
      eff_cnt   = sync ? '0 : counter_q;
      eff_phase = sync ? COUNTER_WIDTH'(clamp_phase(32'(phase_sel), DECIMATION_FACTOR))
                       : phase_q;
      accept    = dec_in_valid & clk_enable;
      keep      = accept & (eff_cnt == eff_phase);
      counter_d = eff_cnt;
      if (accept) begin
         counter_d = (eff_cnt == LAST_POS) ? '0 : eff_cnt + 1'b1;
      end
   end

   assign dec_out_valid = ~fifo_empty;
   assign dec_out       = fifo_head;
   assign pop           = dec_out_valid & dec_out_ready & clk_enable;
   assign drop          = keep & fifo_full & ~pop;
   // A drop in the sync cycle wins over the clear.
   assign overflow_d    = drop | (overflow_q & ~sync);
   assign overflow      = overflow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter_q  <= '0;
         phase_q    <= '0;
         overflow_q <= 1'b0;
      end else if (clk_enable) begin
         counter_q  <= counter_d;
         overflow_q <= overflow_d;
         if (sync) begin
            phase_q <= eff_phase;
         end
      end
   end

`ifdef DECIMATOR_AVG_EN
   localparam int unsigned ACC_WIDTH = DATA_WIDTH + COUNTER_WIDTH + 1;

   logic signed [ACC_WIDTH-1:0] acc_q;
   logic signed [ACC_WIDTH-1:0] acc_d;
   logic signed [ACC_WIDTH-1:0] acc_base;
   logic signed [ACC_WIDTH-1:0] frame_sum;
   logic signed [ACC_WIDTH-1:0] frame_avg;

   always_comb begin
      acc_base  = sync ? '0 : acc_q;
      frame_sum = acc_base + ACC_WIDTH'(dec_in);
      frame_avg = frame_sum >>> AVG_SHIFT;
      push_data = DATA_WIDTH'(sat_wide(wide_t'(frame_avg), DATA_WIDTH));
      acc_d     = acc_base;
      if (accept) begin
         acc_d = keep ? '0 : frame_sum;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (clk_enable) begin
         acc_q <= acc_d;
      end
   end
`else
   assign push_data = dec_in;
`endif

   decim_out_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (OUT_FIFO_DEPTH)
   ) u_out_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .clk_enable (clk_enable),
      .push       (keep),
      .push_data  (push_data),
      .pop        (pop),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

endmodule
